// File: rtl/c17_bist_ctrl.sv
// c17_bist_ctrl
//   Built-in self-test controller for the c17 combinational benchmark.
//   It steps exhaustively through all 32 input patterns on N1/N2/N3/N6/N7.
//   Each pattern is held for SETTLE_CYCLES in APPLY, then N22/N23 are
//   captured into a 16-bit MISR during a single CAPTURE cycle.
//   After pattern 31 the controller parks in DONE. There it compares the
//   signature against golden_sig.
//
// Parameters
//   SETTLE_CYCLES  cycles each pattern is held before capture (1..15)
//   MISR_SEED      signature value loaded when a run starts
//   MISR_POLY      MISR feedback polynomial
//
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   start               pulse; begins a run from IDLE or DONE
//   abort               synchronous abort back to IDLE (beats start)
//   golden_sig[15:0]    expected final signature, compared in DONE
//   resp_n22, resp_n23  c17 responses
//   pat_n1..pat_n7      registered c17 stimulus, pat_n1 is the MSB of pat_idx
//   pat_idx[4:0]        current pattern index
//   busy                high in APPLY and CAPTURE
//   done                high in DONE
//   pass                high in DONE when signature matches golden_sig
//   signature[15:0]     current MISR contents
module c17_bist_ctrl #(
    parameter int          SETTLE_CYCLES = 1,
    parameter logic [15:0] MISR_SEED     = 16'h0000,
    parameter logic [15:0] MISR_POLY     = 16'h1021
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic [15:0] golden_sig,
    input  logic        resp_n22,
    input  logic        resp_n23,
    output logic        pat_n1,
    output logic        pat_n2,
    output logic        pat_n3,
    output logic        pat_n6,
    output logic        pat_n7,
    output logic [4:0]  pat_idx,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] signature
);

    typedef enum logic [1:0] {IDLE, APPLY, CAPTURE, DONE} state_t;

    localparam logic [3:0] CNT_LAST = 4'(SETTLE_CYCLES - 1);

    state_t      state_q, state_d;
    logic [4:0]  idx_q;
    logic [4:0]  pat_q;
    logic [15:0] sig_q;
    logic [3:0]  cnt_q;
    logic        start_run;
    logic        capture;
    logic        advance;

    function automatic logic [15:0] misr_step(input logic [15:0] sig,
                                              input logic [1:0]  r);
        return {sig[14:0], 1'b0} ^ (sig[15] ? MISR_POLY : 16'h0000) ^ {14'b0, r};
    endfunction

    always_comb begin
        state_d   = state_q;
        start_run = 1'b0;
        capture   = 1'b0;
        advance   = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    start_run = 1'b1;
                    state_d   = APPLY;
                end
            end
            APPLY: begin
                if (cnt_q == CNT_LAST) state_d = CAPTURE;
            end
            CAPTURE: begin
                capture = 1'b1;
                if (idx_q == 5'd31) begin
                    state_d = DONE;
                end else begin
                    advance = 1'b1;
                    state_d = APPLY;
                end
            end
            default: state_d = IDLE;
        endcase
        // Abort overrides every transition and suppresses all datapath updates.
        if (abort) begin
            state_d   = IDLE;
            start_run = 1'b0;
            capture   = 1'b0;
            advance   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // pat_q is kept apart from idx_q because abort clears the stimulus while
    // the index is retained for post-mortem inspection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q <= 5'd0;
            pat_q <= 5'd0;
            sig_q <= MISR_SEED;
            cnt_q <= 4'd0;
        end else if (abort) begin
            pat_q <= 5'd0;
        end else if (start_run) begin
            idx_q <= 5'd0;
            pat_q <= 5'd0;
            sig_q <= MISR_SEED;
            cnt_q <= 4'd0;
        end else if (state_q == APPLY) begin
            cnt_q <= cnt_q + 4'd1;
        end else if (capture) begin
            sig_q <= misr_step(sig_q, {resp_n22, resp_n23});
            if (advance) begin
                idx_q <= idx_q + 5'd1;
                pat_q <= idx_q + 5'd1;
                cnt_q <= 4'd0;
            end
        end
    end

    assign {pat_n1, pat_n2, pat_n3, pat_n6, pat_n7} = pat_q;
    assign pat_idx   = idx_q;
    assign signature = sig_q;
    assign busy      = (state_q == APPLY) || (state_q == CAPTURE);
    assign done      = (state_q == DONE);
    assign pass      = done && (sig_q == golden_sig);

endmodule

// File: doc/c17_bist_ctrl.md
Name: c17_bist_ctrl

Overview:
- Self-test controller wrapped around the c17 combinational benchmark.
- Upstream, it drives exhaustive input patterns onto N1/N2/N3/N6/N7.
- Downstream, it samples N22/N23 after a settle window and compacts the responses into a 16-bit MISR.
- At the end of a run it compares the MISR signature against a golden value and reports pass/fail. It is used to check original and locked c17 variants on silicon or in simulation.

Parameters:
- SETTLE_CYCLES, 1, cycles each pattern is held before capture (legal range 1..15).
- MISR_SEED, 16'h0000, MISR value loaded on run start.
- MISR_POLY, 16'h1021, MISR feedback polynomial (x^16+x^12+x^5+1).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle pulse; begins a run when sampled in IDLE or DONE.
- abort  in  1  synchronous abort; returns to IDLE from any state.
- golden_sig  in  16  expected final signature; sampled in DONE.
- resp_n22  in  1  c17 output N22.
- resp_n23  in  1  c17 output N23.
- pat_n1, pat_n2, pat_n3, pat_n6, pat_n7  out  1 each  drive c17 inputs.
- pat_idx  out  5  current pattern index.
- busy  out  1  high in APPLY and CAPTURE.
- done  out  1  high in DONE.
- pass  out  1  high in DONE when signature == golden_sig.
- signature  out  16  current MISR contents.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - pat_idx=0; all pat_* outputs=0.
  - busy=0, done=0, pass=0.
  - signature=MISR_SEED; settle counter=0.
- Pattern mapping: {pat_n1,pat_n2,pat_n3,pat_n6,pat_n7} = pat_idx, with pat_n1 as the MSB.
- Pattern outputs are registered and change only on entry to APPLY.
- States: IDLE, APPLY, CAPTURE, DONE.
- IDLE:
  - On start=1: pat_idx<=0, signature<=MISR_SEED, settle counter<=0, go to APPLY.
- APPLY:
  - Hold the current pattern and increment the settle counter.
  - When counter==SETTLE_CYCLES-1: go to CAPTURE.
- CAPTURE (1 cycle):
  - r = {resp_n22,resp_n23}.
  - signature <= {sig[14:0],1'b0} ^ (sig[15] ? MISR_POLY : 0) ^ {14'b0, r}.
  - If pat_idx==31: go to DONE.
  - Otherwise: pat_idx<=pat_idx+1, counter<=0, go to APPLY.
- DONE:
  - done=1; pass = (signature==golden_sig), evaluated combinationally from the registered signature.
  - Hold until start (restarts as from IDLE) or abort.
- Latency: a start accepted at edge k puts APPLY in force from k+1 and asserts done at edge k+1+32*(SETTLE_CYCLES+1). With the default this is 64 cycles after k+1.
- pat_idx wrap: there is no wrap. Index 31 is terminal and the run ends.
- abort:
  - Takes priority over start and over every transition.
  - Next state is IDLE; busy=0 and done=0.
  - signature and pat_idx hold their values; pat_* outputs are forced to 0.
- start during APPLY or CAPTURE is ignored.
- start and abort in the same cycle: abort wins.
- rst_n asserted mid-run: immediate return to reset values. No partial signature is retained.
- X on resp inputs is not filtered; the bench must keep the DUT outputs defined.

Test Plan:
- Reset then idle: rst_n low 3 cycles, release, no start -> all outputs 0, signature=0x0000, state stays IDLE for 20 cycles.
- Sequence check with real c17, SETTLE=1:
  - Pulse start -> pat outputs go 00000, 00001, 00010 ... 11111, each held 2 cycles.
  - busy high for exactly 64 cycles, then done=1.
- Early signature: real c17, seed 0 -> after capture of pattern 0, signature=0x0000; after pattern 1 (N7=1, N23=1), 0x0001; after pattern 2, 0x0002.
- Pass/fail:
  - golden_sig = value from the bench reference model of the full 32-pattern run -> pass=1.
  - Same run with golden_sig bit 0 flipped -> pass=0 and done=1.
  - Stuck-at-0 stub on N23 -> pass=0.
- Abort mid-run: start, abort at pattern 10 -> next cycle IDLE, busy=0, pat_*=0, pat_idx=10. A following start restarts at pat_idx=0 with signature=seed.
- Restart and corners:
  - start in DONE -> new run whose final signature is identical to the first.
  - start+abort in the same cycle in IDLE -> stays IDLE.
  - rst_n pulse during CAPTURE -> all reset values, asynchronously.
